// File: rtl/riscv_pkg.sv
// Shared core types and constants used by the fetch stage and the IF/ID register.
package riscv_pkg;

  // First fetch address after reset
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [31:0] pc_plus4;
    logic        valid_if_id;
  } if_id_reg_t;

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request at a time,
// holds a fetched word under stall and drops wrong-path responses after a redirect.
// Optional: define IF_STAGE_PERF_EN to add the fetch / memory-wait performance counters.
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = riscv_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output if_id_reg_t  fetch_out,
  output logic        fetch_busy
`ifdef IF_STAGE_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_mem_wait_cnt
`endif
);

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StHold,
    StDrop
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_target;
  logic        deliver_valid;

  // Low two bits of the redirect target are ignored; the target is always word aligned.
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign pc_plus4        = pc_q + 32'd4;

  // Next-state, PC and hold-buffer update; redirect overrides everything else.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    unique case (state_q)
      StReq: begin
        if (redirect) begin
          pc_d = redirect_target;
        end else if (imem_req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (imem_resp_valid) begin
          if (redirect) begin
            pc_d    = redirect_target;
            state_d = StReq;
          end else if (!stall) begin
            pc_d    = pc_plus4;
            state_d = StReq;
          end else begin
            hold_d  = imem_resp_data;
            state_d = StHold;
          end
        end else if (redirect) begin
          // The in-flight response belongs to the old path and must be swallowed.
          pc_d    = redirect_target;
          state_d = StDrop;
        end
      end
      StHold: begin
        if (redirect) begin
          pc_d    = redirect_target;
          state_d = StReq;
        end else if (!stall) begin
          pc_d    = pc_plus4;
          state_d = StReq;
        end
      end
      StDrop: begin
        if (redirect) begin
          pc_d = redirect_target;
        end
        if (imem_resp_valid) begin
          state_d = StReq;
        end
      end
      default: state_d = StReq;
    endcase
  end

  // Fetch state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StReq;
      pc_q    <= RESET_PC;
      hold_q  <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
    end
  end

  // Request channel and IF/ID bundle; response data passes straight through in WAIT.
  always_comb begin
    imem_req_valid = (state_q == StReq) && !redirect && !reset;
    imem_req_addr  = pc_q;
    fetch_busy     = (state_q == StWait) || (state_q == StDrop);
    deliver_valid  = !redirect &&
                     (((state_q == StWait) && imem_resp_valid) || (state_q == StHold));

    fetch_out.pc          = pc_q;
    fetch_out.pc_plus4    = pc_plus4;
    fetch_out.valid_if_id = deliver_valid;
    fetch_out.instruction = NOP_INSTR;
    if (deliver_valid) begin
      fetch_out.instruction = (state_q == StHold) ? hold_q : imem_resp_data;
    end
  end

`ifdef IF_STAGE_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] wait_cnt_q;

  // Count delivered instructions and cycles spent waiting on memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      if (deliver_valid && !stall) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if ((state_q == StWait) && !imem_resp_valid) begin
        wait_cnt_q <= wait_cnt_q + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt    = fetch_cnt_q;
  assign perf_mem_wait_cnt = wait_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: inputs change on the falling edge, outputs checked 1 time
// unit later, state advances on the rising edge. Build with IF_STAGE_PERF_EN to also
// check the performance counters.
module tb_if_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  if_id_reg_t  fetch_out;
  logic        fetch_busy;
`ifdef IF_STAGE_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_mem_wait_cnt;
`endif

  int total = 0;
  int bad   = 0;

  if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .fetch_out       (fetch_out),
    .fetch_busy      (fetch_busy)
`ifdef IF_STAGE_PERF_EN
    ,
    .perf_fetch_cnt    (perf_fetch_cnt),
    .perf_mem_wait_cnt (perf_mem_wait_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full bundle check: pc, instruction, pc_plus4, valid.
  task automatic chk_bundle(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                            input logic [31:0] pc4, input logic v);
    chk({tag, ".pc"}, fetch_out.pc, pc);
    chk({tag, ".instr"}, fetch_out.instruction, ins);
    chk({tag, ".pc4"}, fetch_out.pc_plus4, pc4);
    chk({tag, ".valid"}, {31'd0, fetch_out.valid_if_id}, {31'd0, v});
  endtask

  task automatic chk_req(input string tag, input logic v, input logic [31:0] addr);
    chk({tag, ".req_valid"}, {31'd0, imem_req_valid}, {31'd0, v});
    if (v) chk({tag, ".req_addr"}, imem_req_addr, addr);
  endtask

  // Advance to the falling edge, apply inputs, settle.
  task automatic cyc(input logic rv, input logic [31:0] data, input logic st,
                     input logic rd, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    imem_resp_valid = rv;
    imem_resp_data  = data;
    stall           = st;
    redirect        = rd;
    redirect_pc     = rpc;
    imem_req_ready  = rdy;
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    #1;
    chk_req("rst", 1'b0, 32'h0);
    chk_bundle("rst", 32'h0, 32'h13, 32'h4, 1'b0);
    chk("rst.busy", {31'd0, fetch_busy}, 32'd0);
`ifdef IF_STAGE_PERF_EN
    chk("rst.perf_fetch", perf_fetch_cnt, 32'd0);
    chk("rst.perf_wait", perf_mem_wait_cnt, 32'd0);
`endif

    // Release reset; first request at 0x0.
    @(negedge clk); reset = 1'b0; #1;
    chk_req("c1", 1'b1, 32'h0);
    cyc(1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0, 1'b1);
    chk_bundle("c2", 32'h0, 32'h0000_0013, 32'h4, 1'b1);
    chk_req("c2", 1'b0, 32'h0);
    chk("c2.busy", {31'd0, fetch_busy}, 32'd1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk_req("c3", 1'b1, 32'h4);
    chk_bundle("c3", 32'h4, 32'h13, 32'h8, 1'b0);
    cyc(1'b1, 32'h0010_0093, 1'b0, 1'b0, 32'h0, 1'b1);
    chk_bundle("c4", 32'h4, 32'h0010_0093, 32'h8, 1'b1);

    // Stall across the response for 0x8: held for three cycles.
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk_req("c5", 1'b1, 32'h8);
    cyc(1'b1, 32'hAAAA_0001, 1'b1, 1'b0, 32'h0, 1'b1);
    chk_bundle("c6", 32'h8, 32'hAAAA_0001, 32'hC, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk_bundle("c7", 32'h8, 32'hAAAA_0001, 32'hC, 1'b1);
    chk_req("c7", 1'b0, 32'h0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk_bundle("c8", 32'h8, 32'hAAAA_0001, 32'hC, 1'b1);
    chk("c8.busy", {31'd0, fetch_busy}, 32'd0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk_bundle("c9", 32'h8, 32'hAAAA_0001, 32'hC, 1'b1);
    chk_req("c9", 1'b0, 32'h0);

    // Memory not ready for four cycles: request held stable.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk_req("nrdy", 1'b1, 32'hC);
      chk("nrdy.busy", {31'd0, fetch_busy}, 32'd0);
    end
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk_req("c14", 1'b1, 32'hC);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("c15.busy", {31'd0, fetch_busy}, 32'd1);
    chk_bundle("c15", 32'hC, 32'h13, 32'h10, 1'b0);
    cyc(1'b1, 32'h0000_0011, 1'b0, 1'b0, 32'h0, 1'b1);
    chk_bundle("c16", 32'hC, 32'h0000_0011, 32'h10, 1'b1);
`ifdef IF_STAGE_PERF_EN
    chk("c16.perf_fetch", perf_fetch_cnt, 32'd3);
    chk("c16.perf_wait", perf_mem_wait_cnt, 32'd1);
`endif

    // Redirect while waiting for 0x10: the late response is dropped.
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk_req("c17", 1'b1, 32'h10);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 1'b1);
    chk_bundle("c18", 32'h10, 32'h13, 32'h14, 1'b0);
    chk_req("c18", 1'b0, 32'h0);
    cyc(1'b1, 32'h0000_0055, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("c19.valid", {31'd0, fetch_out.valid_if_id}, 32'd0);
    chk("c19.busy", {31'd0, fetch_busy}, 32'd1);
    chk("c19.pc", fetch_out.pc, 32'h100);

    // Unaligned redirect in REQ with ready high: no request that cycle.
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h203, 1'b1);
    chk_req("c20", 1'b0, 32'h0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk_req("c21", 1'b1, 32'h200);
    cyc(1'b1, 32'h0000_0077, 1'b0, 1'b0, 32'h0, 1'b1);
    chk_bundle("c22", 32'h200, 32'h0000_0077, 32'h204, 1'b1);

    // Wrap-around at the top of the address space.
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    chk_req("c23", 1'b0, 32'h0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk_req("c24", 1'b1, 32'hFFFF_FFFC);
    cyc(1'b1, 32'h0000_0099, 1'b0, 1'b0, 32'h0, 1'b1);
    chk_bundle("c25", 32'hFFFF_FFFC, 32'h0000_0099, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk_req("c26", 1'b1, 32'h0);
`ifdef IF_STAGE_PERF_EN
    chk("c26.perf_fetch", perf_fetch_cnt, 32'd6);
    chk("c26.perf_wait", perf_mem_wait_cnt, 32'd2);
`endif

    // Asynchronous reset in the middle of WAIT.
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("c27.busy", {31'd0, fetch_busy}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk_req("arst", 1'b0, 32'h0);
    chk("arst.busy", {31'd0, fetch_busy}, 32'd0);
    chk_bundle("arst", 32'h0, 32'h13, 32'h4, 1'b0);
`ifdef IF_STAGE_PERF_EN
    chk("arst.perf_fetch", perf_fetch_cnt, 32'd0);
    chk("arst.perf_wait", perf_mem_wait_cnt, 32'd0);
`endif
    @(negedge clk); reset = 1'b0; #1;
    chk_req("post_rst", 1'b1, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage directly upstream of the IF/ID pipeline register. Owns the program counter, issues one-outstanding-at-a-time requests to instruction memory over a valid/ready request channel and a valid-only response channel, and presents each fetched instruction as an `if_id_reg_t` bundle. Handles back-pressure from the hazard unit (`stall`) and control-flow redirects from EX (`redirect`), discarding wrong-path responses.

## Interface
- `RESET_PC`, default `riscv_pkg::RESET_PC`: first fetch address after reset.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `stall`  in  1  downstream not accepting this cycle; the presented bundle must be held.
- `redirect`  in  1  control-flow change; overrides `stall` and all fetch state.
- `redirect_pc`  in  32  new fetch target; bits [1:0] ignored (treated as 00).
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_addr`  out  32  fetch address (word aligned).
- `imem_req_ready`  in  1  memory accepts request when `valid && ready`.
- `imem_resp_valid`  in  1  response data valid; arrives ≥1 cycle after acceptance.
- `imem_resp_data`  in  32  fetched instruction word.
- `fetch_out`  out  `if_id_reg_t`  {pc, instruction, pc_plus4, valid_if_id} to IF/ID register.
- `fetch_busy`  out  1  high in WAIT or DROP (request outstanding).
- `perf_fetch_cnt`, `perf_mem_wait_cnt`  out  32 each  present only with `IF_STAGE_PERF_EN`.

## Operation
- State: `pc` (32), FSM {REQ, WAIT, HOLD, DROP}, hold buffer (32-bit instruction).
- REQ: `imem_req_valid = !redirect`, `imem_req_addr = pc`. On acceptance → WAIT. Requests issue regardless of `stall`.
- WAIT: awaiting response. Response with `stall=0`: bundle valid this cycle, `pc <= pc+4`, → REQ. Response with `stall=1`: capture data into hold buffer, → HOLD.
- HOLD: bundle valid from hold buffer; when `stall=0` it is consumed, `pc <= pc+4`, → REQ.
- DROP: wrong-path response outstanding; on `imem_resp_valid`, discard it, → REQ.
- `fetch_out`: pc = `pc`, pc_plus4 = `pc+4` (mod 2^32), instruction = response data (WAIT) or hold buffer (HOLD), valid_if_id = 1 only in those two cases and `redirect=0`; otherwise instruction = `NOP_INSTR`, valid_if_id = 0.
- Redirect (highest priority, any state): `pc <= {redirect_pc[31:2],2'b00}`, valid_if_id forced 0. Next state: REQ from REQ/HOLD/WAIT-with-response-this-cycle; DROP from WAIT-without-response; DROP stays DROP unless the response arrives that same cycle (→ REQ). Latest redirect wins.
- `imem_resp_valid` in REQ or HOLD is ignored (protocol violation; no state change).
- Wrap-around: pc 0xFFFF_FFFC + 4 → 0x0000_0000.

## Timing
- Reset (async assert, sync release): pc = RESET_PC, state REQ, `imem_req_valid = 0` while reset high, `fetch_out` = {RESET_PC, NOP_INSTR, RESET_PC+4, 0}, `fetch_busy = 0`, perf counters 0.
- First request: first rising edge after reset deasserts, with `imem_req_valid` high in that cycle.
- Latency: response cycle = bundle cycle (combinational pass-through from `imem_resp_data`); IF/ID captures it at the next edge.
- Throughput: one instruction per 2 cycles with 1-cycle memory and ready always high.
- Reset mid-WAIT/DROP: state returns to REQ; memory is reset with the core, so no stale response follows.
- `stall` and `redirect` in the same cycle: redirect wins; nothing is delivered.

## Configuration
- `IF_STAGE_PERF_EN` defined: `perf_fetch_cnt` increments on each delivered instruction (valid_if_id && !stall); `perf_mem_wait_cnt` increments each cycle in WAIT without `imem_resp_valid`. Both 32-bit, wrap, reset to 0.
- Not defined: both ports and counters absent; all other behaviour identical.

## Test plan
- Reset release, ready=1, 1-cycle memory returning 0x00000013, 0x00100093 → requests at 0x0 then 0x4; bundles {0x0, 0x00000013, 0x4, 1}, then {0x4, 0x00100093, 0x8, 1}, one every 2 cycles.
- `stall` high 3 cycles across response for pc 0x8 → bundle held constant 3 cycles (HOLD), pc unchanged, no new request; released → pc 0xC requested next cycle.
- `redirect` to 0x100 while in WAIT for 0x10, response one cycle later → that response dropped (valid 0), next request addr 0x100.
- `redirect_pc` = 0x203 in REQ, same cycle as ready=1 → `imem_req_valid` 0 that cycle; next request addr 0x200.
- `imem_req_ready` low 4 cycles → `imem_req_valid` stays high with stable addr; with `IF_STAGE_PERF_EN`, `perf_mem_wait_cnt` counts only WAIT cycles.
- pc = 0xFFFFFFFC delivered → pc_plus4 = 0x00000000, next request addr 0x0; async reset mid-WAIT → outputs return to reset values immediately.
